controle_nivel: RTL
===================

CONTROLE_NIVEL -- requirements
Module: controle_nivel

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 1000, is the number of consecutive stable cycles required before a sensor change is accepted.
REQ-002 Parameter TIMEOUT_CICLOS, default 50000000, is the maximum number of cycles allowed in ENCHENDO before a fault is declared.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ligar  input  1  automatic-control enable; 1 = run, 0 = idle.
REQ-006 sensor_baixo  input  1  raw low-mark sensor, asynchronous; 1 = water at or above the low mark.
REQ-007 sensor_alto  input  1  raw high-mark sensor, asynchronous; 1 = water at or above the high mark.
REQ-008 abre_auto  output  1  one-cycle open command to the valve stage.
REQ-009 fecha_auto  output  1  one-cycle close command to the valve stage.
REQ-010 alarme  output  1  fault indicator; level, not pulse.
REQ-011 db_estado  output  3  current FSM state encoding.
REQ-012 db_baixo, db_alto  output  1 each  filtered sensor values.

Function
REQ-013 Each raw sensor SHALL pass through a 2-flop synchronizer, then a debounce filter whose output takes the new value only after the synchronized input has differed from it for DEBOUNCE_CICLOS consecutive cycles; any bounce restarts the count.
REQ-014 FSM states SHALL be INICIAL=000, ESPERA=001, ENCHENDO=010 and ERRO=111.
REQ-015 INICIAL -> ESPERA when ligar=1.
REQ-016 ESPERA -> ENCHENDO when filtered baixo=0, issuing abre_auto.
REQ-017 ENCHENDO -> ESPERA when filtered alto=1, issuing fecha_auto.
REQ-018 ENCHENDO -> ERRO when the fill timer reaches TIMEOUT_CICLOS, issuing fecha_auto; the timer clears on every entry to ENCHENDO.
REQ-019 In ESPERA or ENCHENDO, filtered alto=1 with baixo=0 (inconsistent sensors) -> ERRO, issuing fecha_auto.
REQ-020 In ESPERA, ENCHENDO or ERRO, ligar=0 -> INICIAL; fecha_auto is issued only when leaving ENCHENDO.
REQ-021 Simultaneous conditions SHALL be resolved in this priority order: ligar=0, then inconsistency, then timeout, then alto reached.
REQ-022 abre_auto and fecha_auto SHALL be registered and high for exactly one cycle, the first cycle the new state is held; they are never high together.
REQ-023 alarme SHALL be 1 exactly while the state is ERRO; ERRO is exited only via ligar=0.
REQ-024 Latency from a raw sensor edge to the filtered value SHALL be 2+DEBOUNCE_CICLOS cycles, plus 1 cycle to the state change and command pulse.
REQ-025 Counters SHALL saturate and never wrap; the timer width SHALL be the minimum width that holds TIMEOUT_CICLOS.

Reset
REQ-026 On reset the state SHALL be INICIAL, abre_auto=0, fecha_auto=0, alarme=0, all counters 0, synchronizer flops 0, and filtered sensors 0.
REQ-027 Reset asserted mid-fill SHALL return the block to INICIAL immediately with no fecha_auto pulse; the valve stage handles its own state.

Structure
REQ-028 State encodings and the default parameter values SHALL live in the shared package aqua_pkg.
REQ-029 The synchronizer and debounce logic SHALL be the sub-module filtro_sensor, instantiated once per sensor.

Verification (DEBOUNCE_CICLOS=4, TIMEOUT_CICLOS=100)
REQ-030 Normal cycle: reset, ligar=1, sensor_baixo=0 -> ENCHENDO, and one abre_auto pulse 7 cycles after the sensor edge; then sensor_baixo=1 and sensor_alto=1 -> ESPERA and one fecha_auto pulse.
REQ-031 Bounce: sensor_baixo toggles every 2 cycles for 20 cycles -> db_baixo is unchanged and no command pulse occurs.
REQ-032 Timeout: ENCHENDO is held with alto=0 for 100 cycles -> ERRO, fecha_auto pulse, alarme=1; then ligar=0 -> INICIAL and alarme=0.
REQ-033 Inconsistency: in ESPERA, force filtered alto=1 and baixo=0 -> ERRO with one fecha_auto pulse.
REQ-034 Priority: ligar=0 in the same cycle that alto is accepted -> INICIAL, exactly one fecha_auto pulse, alarme=0.
REQ-035 Asynchronous reset asserted mid-ENCHENDO between clock edges -> all outputs 0 and db_estado=000 before the next edge.

Source files
------------

// File: rtl/aqua_pkg.sv
// Shared definitions for the water-level controller: state encodings,
// default timing parameters and a width helper for saturating counters.
package aqua_pkg;

  localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 1000;
  localparam int unsigned TIMEOUT_CICLOS_PADRAO  = 50000000;
  localparam int unsigned ESTADO_W               = 3;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL  = 3'b000,
    ESPERA   = 3'b001,
    ENCHENDO = 3'b010,
    ERRO     = 3'b111
  } estado_t;

  // Minimum number of bits that can hold the value 'valor' (at least 1).
  function automatic int unsigned largura_para(input int unsigned valor);
    return (valor == 0) ? 1 : $clog2(valor + 1);
  endfunction

endpackage

// File: rtl/controle_nivel_if.sv
// Control/status bundle of the water-level controller.
//   ligar, sensor_baixo, sensor_alto : enable and raw sensors (into the block)
//   abre_auto, fecha_auto            : one-cycle valve commands (out of the block)
//   alarme                           : fault level
//   db_estado, db_baixo, db_alto     : debug view of state and filtered sensors
interface controle_nivel_if;

  logic       ligar;
  logic       sensor_baixo;
  logic       sensor_alto;
  logic       abre_auto;
  logic       fecha_auto;
  logic       alarme;
  logic [2:0] db_estado;
  logic       db_baixo;
  logic       db_alto;

  modport master (
    output ligar, sensor_baixo, sensor_alto,
    input  abre_auto, fecha_auto, alarme, db_estado, db_baixo, db_alto
  );

  modport slave (
    input  ligar, sensor_baixo, sensor_alto,
    output abre_auto, fecha_auto, alarme, db_estado, db_baixo, db_alto
  );

endinterface

// File: rtl/filtro_sensor.sv
// Sensor conditioning: 2-flop synchronizer followed by a debounce filter.
// The filtered output adopts the synchronized value only after it has
// differed from the current output for DEBOUNCE_CICLOS consecutive cycles.
//   clock, reset : system clock, asynchronous active-high reset
//   bruto        : raw asynchronous sensor
//   filtrado     : registered, debounced sensor value
module filtro_sensor
  import aqua_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic bruto,
  output logic filtrado
);

  localparam int unsigned      CONT_W      = largura_para(DEBOUNCE_CICLOS);
  localparam logic [CONT_W-1:0] CONT_ULTIMO = CONT_W'(DEBOUNCE_CICLOS - 1);
  localparam logic [CONT_W-1:0] CONT_MAX    = CONT_W'(DEBOUNCE_CICLOS);

  logic              sinc1_q;
  logic              sinc2_q;
  logic              filtrado_q;
  logic [CONT_W-1:0] cont_q;

  // Metastability synchronizer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc1_q <= 1'b0;
      sinc2_q <= 1'b0;
    end else begin
      sinc1_q <= bruto;
      sinc2_q <= sinc1_q;
    end
  end

  // Debounce: the count is the run length of cycles disagreeing with the
  // output; the output flips on the cycle that completes the run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont_q     <= '0;
      filtrado_q <= 1'b0;
    end else if (sinc2_q == filtrado_q) begin
      cont_q <= '0;
    end else if (cont_q == CONT_ULTIMO) begin
      filtrado_q <= sinc2_q;
      cont_q     <= '0;
    end else if (cont_q != CONT_MAX) begin
      cont_q <= cont_q + CONT_W'(1);
    end
  end

  assign filtrado = filtrado_q;

endmodule

// File: rtl/controle_nivel.sv
// Automatic tank-fill controller. Opens the valve when the low mark is lost,
// closes it when the high mark is reached, and latches a fault on fill
// timeout or inconsistent sensors until the enable is dropped.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : enable, raw sensors, valve command pulses, alarm, debug
module controle_nivel
  import aqua_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
  parameter int unsigned TIMEOUT_CICLOS  = TIMEOUT_CICLOS_PADRAO
) (
  input  logic             clock,
  input  logic             reset,
  controle_nivel_if.slave  bus
);

  localparam int unsigned       TIMER_W      = largura_para(TIMEOUT_CICLOS);
  localparam logic [TIMER_W-1:0] TIMER_ULTIMO = TIMER_W'(TIMEOUT_CICLOS - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX    = TIMER_W'(TIMEOUT_CICLOS);

  logic               baixo_f;
  logic               alto_f;
  estado_t            estado_q;
  estado_t            estado_d;
  logic               abre_q;
  logic               abre_d;
  logic               fecha_q;
  logic               fecha_d;
  logic               alarme_q;
  logic [TIMER_W-1:0] timer_q;
  logic               inconsistente_c;
  logic               timeout_c;

  filtro_sensor #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_filtro_baixo (
    .clock    (clock),
    .reset    (reset),
    .bruto    (bus.sensor_baixo),
    .filtrado (baixo_f)
  );

  filtro_sensor #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_filtro_alto (
    .clock    (clock),
    .reset    (reset),
    .bruto    (bus.sensor_alto),
    .filtrado (alto_f)
  );

  // High mark wet while low mark dry cannot happen with healthy sensors.
  assign inconsistente_c = alto_f && !baixo_f;
  // Timer holds cycles already spent in ENCHENDO; this is the last allowed one.
  assign timeout_c       = (timer_q == TIMER_ULTIMO);

  // State register plus registered command/alarm outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIAL;
      abre_q   <= 1'b0;
      fecha_q  <= 1'b0;
      alarme_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      abre_q   <= abre_d;
      fecha_q  <= fecha_d;
      alarme_q <= (estado_d == ERRO);
    end
  end

  // Next state and command pulses; earlier branches take priority.
  always_comb begin
    estado_d = estado_q;
    abre_d   = 1'b0;
    fecha_d  = 1'b0;
    case (estado_q)
      INICIAL: begin
        if (bus.ligar) estado_d = ESPERA;
      end
      ESPERA: begin
        if (!bus.ligar) begin
          estado_d = INICIAL;
        end else if (inconsistente_c) begin
          estado_d = ERRO;
          fecha_d  = 1'b1;
        end else if (!baixo_f) begin
          estado_d = ENCHENDO;
          abre_d   = 1'b1;
        end
      end
      ENCHENDO: begin
        if (!bus.ligar) begin
          estado_d = INICIAL;
          fecha_d  = 1'b1;
        end else if (inconsistente_c || timeout_c) begin
          estado_d = ERRO;
          fecha_d  = 1'b1;
        end else if (alto_f) begin
          estado_d = ESPERA;
          fecha_d  = 1'b1;
        end
      end
      ERRO: begin
        if (!bus.ligar) estado_d = INICIAL;
      end
      default: begin
        estado_d = INICIAL;
      end
    endcase
  end

  // Fill timer: held at zero outside ENCHENDO, so every entry starts fresh.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (estado_q != ENCHENDO) begin
      timer_q <= '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_q <= timer_q + TIMER_W'(1);
    end
  end

  assign bus.abre_auto  = abre_q;
  assign bus.fecha_auto = fecha_q;
  assign bus.alarme     = alarme_q;
  assign bus.db_estado  = estado_q;
  assign bus.db_baixo   = baixo_f;
  assign bus.db_alto    = alto_f;

endmodule
